// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame sampler.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 24;

  // Largest magnitude a saturated absolute value can take at the default width.
  localparam logic [SAMPLE_W-1:0] SAT_LIMIT = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DONE = 2'd1,
    EMIT = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/audio_frame_sampler_abs_sat.sv
// Saturating absolute value of a two's complement sample.
module abs_sat #(
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] mag_o
);

  localparam logic [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Most negative value has no positive twin, so clamp it to the largest positive.
  always_comb begin
    mag_o = sample_i;
    if (sample_i == MIN_NEG) begin
      mag_o = MAX_POS;
    end else if (sample_i[SAMPLE_W-1]) begin
      mag_o = (~sample_i) + SAMPLE_W'(1);
    end
  end

endmodule

// File: rtl/audio_frame_sampler.sv
// Block-averages codec sample magnitudes and presents one result per video frame.
module audio_frame_sampler
  import audio_pkg::*;
#(
  parameter int unsigned LOG2N    = 3,
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_ready,
  input  logic [SAMPLE_W-1:0] readdata_left,
  input  logic [SAMPLE_W-1:0] readdata_right,
  output logic                read,
  input  logic                frame_tick,
  output logic [SAMPLE_W-1:0] dataL,
  output logic [SAMPLE_W-1:0] dataR,
  output logic                en
);

  localparam int unsigned ACC_W = SAMPLE_W + LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

  sampler_state_t      state_q, state_d;
  logic [LOG2N-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0] avg_l_q, avg_l_d, avg_r_q, avg_r_d;
  logic [SAMPLE_W-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
  logic                en_q, en_d;

  logic [SAMPLE_W-1:0] mag_l, mag_r;
  logic [ACC_W-1:0]    mag_l_ext, mag_r_ext, sum_l, sum_r;
  logic                consume;

  abs_sat #(.SAMPLE_W(SAMPLE_W)) u_abs_l (.sample_i(readdata_left),  .mag_o(mag_l));
  abs_sat #(.SAMPLE_W(SAMPLE_W)) u_abs_r (.sample_i(readdata_right), .mag_o(mag_r));

  // The codec FIFO is always drained; nothing is acknowledged while in reset.
  assign read    = read_ready & ~rst;
  assign consume = read;

  assign mag_l_ext = ACC_W'(mag_l);
  assign mag_r_ext = ACC_W'(mag_r);
  assign sum_l     = acc_l_q + mag_l_ext;
  assign sum_r     = acc_r_q + mag_r_ext;

  // Next-state: accumulate in FILL, wait for the frame in DONE, publish in EMIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    avg_l_d  = avg_l_q;
    avg_r_d  = avg_r_q;
    data_l_d = data_l_q;
    data_r_d = data_r_q;
    en_d     = 1'b0;
    case (state_q)
      FILL: begin
        if (consume) begin
          if (cnt_q == CNT_LAST) begin
            avg_l_d = SAMPLE_W'(sum_l >> LOG2N);
            avg_r_d = SAMPLE_W'(sum_r >> LOG2N);
            acc_l_d = '0;
            acc_r_d = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            acc_l_d = sum_l;
            acc_r_d = sum_r;
            cnt_d   = cnt_q + LOG2N'(1);
          end
        end
      end
      DONE: begin
        if (frame_tick) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        data_l_d = avg_l_q;
        data_r_d = avg_r_q;
        en_d     = 1'b1;
        state_d  = FILL;
        // A pair taken here opens the next block.
        if (consume) begin
          acc_l_d = mag_l_ext;
          acc_r_d = mag_r_ext;
          cnt_d   = LOG2N'(1);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      avg_l_q  <= '0;
      avg_r_q  <= '0;
      data_l_q <= '0;
      data_r_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      avg_l_q  <= avg_l_d;
      avg_r_q  <= avg_r_d;
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      en_q     <= en_d;
    end
  end

  assign dataL = data_l_q;
  assign dataR = data_r_q;
  assign en    = en_q;

endmodule

// File: tb/tb_audio_frame_sampler.sv
// Directed bench for audio_frame_sampler with LOG2N=2.
module tb_audio_frame_sampler;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_ready;
  logic [W-1:0] readdata_left;
  logic [W-1:0] readdata_right;
  logic         read;
  logic         frame_tick;
  logic [W-1:0] dataL;
  logic [W-1:0] dataR;
  logic         en;

  int checks = 0;
  int errors = 0;
  int en_total = 0;
  int en_consec = 0;
  logic en_prev = 1'b0;

  audio_frame_sampler #(.LOG2N(2), .SAMPLE_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .read_ready    (read_ready),
    .readdata_left (readdata_left),
    .readdata_right(readdata_right),
    .read          (read),
    .frame_tick    (frame_tick),
    .dataL         (dataL),
    .dataR         (dataR),
    .en            (en)
  );

  always #5 clk = ~clk;

  // Counts strobes and back-to-back strobes across the whole run.
  always @(negedge clk) begin
    if (en) en_total = en_total + 1;
    if (en && en_prev) en_consec = en_consec + 1;
    en_prev = en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input int l, input int r);
    read_ready     = 1'b1;
    readdata_left  = W'(l);
    readdata_right = W'(r);
    cyc();
    read_ready     = 1'b0;
  endtask

  // Tick in DONE: EMIT next cycle, strobe and data one cycle later, then strobe drops.
  task automatic tick_expect(input string tag, input int l, input int r);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk({tag, "_en_early"}, 32'(en), 32'd0);
    cyc();
    chk({tag, "_en"}, 32'(en), 32'd1);
    chk({tag, "_dataL"}, 32'(dataL), 32'(l));
    chk({tag, "_dataR"}, 32'(dataR), 32'(r));
    cyc();
    chk({tag, "_en_drop"}, 32'(en), 32'd0);
  endtask

  task automatic tick_expect_none(input string tag, input int l, input int r);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk({tag, "_en_a"}, 32'(en), 32'd0);
    cyc();
    chk({tag, "_en_b"}, 32'(en), 32'd0);
    chk({tag, "_dataL"}, 32'(dataL), 32'(l));
    chk({tag, "_dataR"}, 32'(dataR), 32'(r));
  endtask

  initial begin
    int en_before;
    int read_ok;
    rst            = 1'b1;
    read_ready     = 1'b1;
    readdata_left  = 24'h123456;
    readdata_right = 24'h654321;
    frame_tick     = 1'b0;

    // Reset held two cycles with data offered.
    #1;
    chk("rst_read", 32'(read), 32'd0);
    cyc();
    cyc();
    chk("rst_read2", 32'(read), 32'd0);
    chk("rst_dataL", 32'(dataL), 32'd0);
    chk("rst_dataR", 32'(dataR), 32'd0);
    chk("rst_en", 32'(en), 32'd0);

    // Partial block then reset: those pairs must not leak into the next average.
    rst        = 1'b0;
    read_ready = 1'b0;
    #1;
    chk("idle_read", 32'(read), 32'd0);
    pair(1000, 1000);
    pair(1000, 1000);
    pair(1000, 1000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pair(8, 4);
    pair(8, 4);
    pair(8, 4);
    pair(8, 4);
    tick_expect("reset_mid", 8, 4);

    // Mixed-sign averaging: 1001>>2 = 250, 17>>2 = 4.
    pair(100, 4);
    pair(-200, 4);
    pair(300, 4);
    pair(-401, 5);
    tick_expect("avg", 250, 4);

    // Saturation of the most negative code.
    pair(32'h0080_0000, 32'h007F_FFFF);
    pair(32'h0080_0000, 32'h007F_FFFF);
    pair(32'h0080_0000, 32'h007F_FFFF);
    pair(32'h0080_0000, 32'h007F_FFFF);
    tick_expect("sat", 32'h7F_FFFF, 32'h7F_FFFF);

    // Early tick is ignored; the block then completes as (40+40+60+60)/4, (80+80+100+100)/4.
    pair(40, 80);
    pair(40, 80);
    tick_expect_none("early", 32'h7F_FFFF, 32'h7F_FFFF);
    pair(60, 100);
    pair(60, 100);
    tick_expect("early_next", 50, 90);

    // Last pair and tick in the same cycle: tick missed, next tick emits 44/4, 84/4.
    pair(10, 20);
    pair(10, 20);
    pair(10, 20);
    frame_tick = 1'b1;
    pair(14, 24);
    frame_tick = 1'b0;
    cyc();
    chk("coinc_en_a", 32'(en), 32'd0);
    cyc();
    chk("coinc_en_b", 32'(en), 32'd0);
    chk("coinc_dataL", 32'(dataL), 32'd50);
    tick_expect("coinc_next", 11, 21);

    // Continuous drain: left=2i, right=-3i, ticks at cycles 49/99/149/199.
    en_before = en_total;
    read_ok   = 0;
    for (int i = 0; i < 204; i++) begin
      read_ready     = (i < 200);
      readdata_left  = W'(2 * i);
      readdata_right = W'(-3 * i);
      frame_tick     = (i == 49 || i == 99 || i == 149 || i == 199);
      #1;
      if (i < 200 && read === 1'b1) read_ok = read_ok + 1;
      @(posedge clk);
      #1;
      case (i)
        50: begin
          chk("drain0_en", 32'(en), 32'd1);
          chk("drain0_dataL", 32'(dataL), 32'd3);
          chk("drain0_dataR", 32'(dataR), 32'd4);
        end
        100: begin
          chk("drain1_en", 32'(en), 32'd1);
          chk("drain1_dataL", 32'(dataL), 32'd103);
          chk("drain1_dataR", 32'(dataR), 32'd154);
        end
        150: begin
          chk("drain2_en", 32'(en), 32'd1);
          chk("drain2_dataL", 32'(dataL), 32'd203);
          chk("drain2_dataR", 32'(dataR), 32'd304);
        end
        200: begin
          chk("drain3_en", 32'(en), 32'd1);
          chk("drain3_dataL", 32'(dataL), 32'd303);
          chk("drain3_dataR", 32'(dataR), 32'd454);
        end
        default: ;
      endcase
    end
    read_ready = 1'b0;
    frame_tick = 1'b0;
    cyc();
    cyc();
    chk("drain_read_cycles", 32'(read_ok), 32'd200);
    chk("drain_en_pulses", 32'(en_total - en_before), 32'd4);
    chk("en_never_consecutive", 32'(en_consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_sampler.md
# audio_frame_sampler

Upstream feeder for the audio visualiser stage. Drains two-channel 24-bit samples from the audio codec read port and accumulates magnitudes over a block of 2^LOG2N samples. Once per video frame it presents the block averages as `dataL`/`dataR` with a one-cycle `en` pulse, so the visualiser's sample shift chain advances once per frame instead of at the audio rate.

## Interface
Parameters:
- `LOG2N`, default 3: log2 of the samples averaged per block (N = 8). Legal range is 1..6.
- `SAMPLE_W`, default 24: codec sample width.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `read_ready`, in, 1: codec has a sample pair available.
- `readdata_left`, in, SAMPLE_W: left sample, two's complement, valid while `read_ready`=1.
- `readdata_right`, in, SAMPLE_W: right sample, two's complement, valid while `read_ready`=1.
- `read`, out, 1: consume acknowledge to the codec. Combinational.
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blank.
- `dataL`, out, SAMPLE_W: averaged left magnitude (unsigned), registered.
- `dataR`, out, SAMPLE_W: averaged right magnitude (unsigned), registered.
- `en`, out, 1: one-cycle strobe; `dataL`/`dataR` are new on this cycle.

## Operation
- The block has three states: FILL, DONE and EMIT.
- **Read handshake:**
  - `read` = `read_ready` in every state after reset.
  - `read` = 0 while `rst`=1.
  - A sample pair is consumed in any cycle where `read`=1. The codec FIFO is always drained and never stalls.
- **FILL:**
  - Each consumed pair adds `abs_sat(left)` to `accL` and `abs_sat(right)` to `accR`. Both accumulators are SAMPLE_W+LOG2N bits, unsigned.
  - A sample counter `cnt` (LOG2N bits) increments per consumed pair.
  - When the pair with `cnt` = N-1 is consumed:
    - `avgL` <= (`accL` + abs) >> LOG2N, and likewise `avgR`.
    - `accL`, `accR` and `cnt` clear.
    - Next state is DONE.
- **DONE:**
  - Consumed pairs are discarded; the accumulators stay at 0.
  - `frame_tick`=1 moves to EMIT.
- **EMIT:** lasts exactly one cycle.
  - `dataL` <= `avgL`, `dataR` <= `avgR`, `en` <= 1.
  - A pair consumed in this cycle is the first sample of the next block; it is accumulated with `cnt` -> 1.
  - Next state is FILL.
- **`frame_tick` during FILL:** ignored. No `en` pulse; `dataL`/`dataR` hold their previous values.
- **`abs_sat`:**
  - Non-negative inputs pass through unchanged.
  - Negative inputs are negated.
  - -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
  - Therefore every average is at most 2^(SAMPLE_W-1)-1, and the averaging truncates (floor).

## Timing
- **Reset values:**
  - `dataL` = 0, `dataR` = 0, `en` = 0; `read` is 0 during reset.
  - State = FILL; `accL`, `accR`, `cnt`, `avgL`, `avgR` all 0.
- **Reset mid-operation:** any partial block is discarded, and the first block after reset needs a full N fresh samples.
- **Block completion:** if the last sample is consumed at cycle t, the state is DONE at t+1.
- **`frame_tick` at cycle t while DONE:** the state is EMIT at t+1, and `dataL`/`dataR`/`en` are visible at t+2.
- **Simultaneous last sample and `frame_tick` at cycle t:** the tick is missed (state still FILL); `en` waits for the next frame.
- **`frame_tick` in the EMIT cycle:** ignored.
- **`en`:** never high on two consecutive cycles, and never high more than once per `frame_tick`.
- **Sample rate versus ticks:**
  - Samples (48 kHz) far outnumber frame ticks (60 Hz), so DONE is the normal waiting state.
  - Each emitted average is built from the N samples that follow the previous emit.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`.
  - Enum `sampler_state_t` {FILL, DONE, EMIT}.
  - Function or constant for the saturation limit 2^(SAMPLE_W-1)-1.
- Sub-module `abs_sat`: parameterised SAMPLE_W, combinational, two instances (left and right).
- Expected RTL size is about 150-250 lines, plus the bench.

## Test plan
- **Reset:**
  - Hold `rst`=1 for 2 cycles with `read_ready`=1 -> `read`=0, `dataL`=`dataR`=0, `en`=0.
  - Release and deliver 3 pairs, then assert `rst` for 1 cycle, then deliver 4 pairs of left=8 and right=4 (LOG2N=2), then `frame_tick` -> `dataL`=8, `dataR`=4, with no contribution from the pre-reset pairs.
- **Averaging, LOG2N=2:**
  - left = 100, -200, 300, -401; right = 4, 4, 4, 5.
  - Then `frame_tick` -> `dataL`=250 (1001>>2), `dataR`=4, `en` high exactly 1 cycle, 2 cycles after the tick.
- **Saturation:** 4 pairs with left = 0x800000, right = 0x7FFFFF, then tick -> `dataL`=`dataR`=0x7FFFFF.
- **Early tick:**
  - `frame_tick` after only 2 of 4 pairs -> no `en`; outputs keep their previous values.
  - Complete the block, next tick -> `en` pulses with the new average.
- **Coincident events:** last pair consumed in the same cycle as `frame_tick` -> no `en`; the next `frame_tick` produces `en` with that block's average.
- **Continuous drain:**
  - Hold `read_ready`=1 for 200 cycles with ticks every 50 cycles -> `read`=1 every cycle.
  - Exactly 4 `en` pulses.
  - Each average equals the floor-mean of the N pairs consumed starting at the previous EMIT cycle.
